// File: rtl/pdm_diff_driver_if.sv
// Control and pulse-density output bundle for pdm_diff_driver.
// The master drives enable/load/code; the slave returns ack, the vp/vn pair and status.
interface pdm_diff_driver_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic             load;
  logic [WIDTH-1:0] code_in;
  logic             load_ack;
  logic             vp_out;
  logic             vn_out;
  logic             tick;
  logic             active;

  modport master (
    output ena, load, code_in,
    input  load_ack, vp_out, vn_out, tick, active
  );

  modport slave (
    input  ena, load, code_in,
    output load_ack, vp_out, vn_out, tick, active
  );
endinterface

// File: rtl/pdm_diff_driver.sv
// First-order sigma-delta modulator producing a complementary pulse-density pair (vp/vn).
// Optional macro DEADTIME_EN inserts a one-cycle vp=vn=0 break whenever the output bit changes.
module pdm_diff_driver #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pdm_diff_driver_if.slave   bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

`ifdef DEADTIME_EN
  // The break cycle must fit between two ticks.
  generate
    if (DIV < 2) begin : g_divCheck
      $error("pdm_diff_driver: DEADTIME_EN requires DIV >= 2");
    end
  endgenerate
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_code;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_divCnt;
  logic             r_vp;
  logic             r_vn;
  logic             r_tick;
  logic             r_loadAck;
  logic             r_active;

  logic [WIDTH-1:0] w_codeNext;
  logic [WIDTH-1:0] w_accNext;
  logic [CW-1:0]    w_divNext;
  logic             w_vpNext;
  logic             w_vnNext;
  logic             w_tickNext;
  logic             w_ackNext;
  logic             w_activeNext;
  logic [WIDTH:0]   w_sum;
  logic             w_bit;
  logic             w_tickCycle;

`ifdef DEADTIME_EN
  logic             r_pend;
  logic             r_pendBit;
  logic             w_pendNext;
  logic             w_pendBitNext;
`endif

  assign w_sum       = {1'b0, r_acc} + {1'b0, r_code};
  assign w_bit       = w_sum[WIDTH];
  assign w_tickCycle = (r_divCnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.ena && bus.load) w_nextState = RUN;
      RUN:     if (!bus.ena)            w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Next values of every registered output and the modulator datapath.
  always_comb begin
    w_codeNext    = r_code;
    w_accNext     = r_acc;
    w_divNext     = r_divCnt;
    w_vpNext      = r_vp;
    w_vnNext      = r_vn;
    w_tickNext    = 1'b0;
    w_ackNext     = 1'b0;
    w_activeNext  = 1'b0;
`ifdef DEADTIME_EN
    w_pendNext    = 1'b0;
    w_pendBitNext = r_pendBit;
`endif
    case (r_state)
      IDLE: begin
        w_accNext = '0;
        w_divNext = '0;
        w_vpNext  = 1'b0;
        w_vnNext  = 1'b0;
        if (bus.ena && bus.load) begin
          w_codeNext   = bus.code_in;
          w_ackNext    = 1'b1;
          w_activeNext = 1'b1;
        end
      end
      RUN: begin
        if (!bus.ena) begin
          w_accNext = '0;
          w_divNext = '0;
          w_vpNext  = 1'b0;
          w_vnNext  = 1'b0;
        end else begin
          w_activeNext = 1'b1;
          if (bus.load) begin
            w_codeNext = bus.code_in;
            w_ackNext  = 1'b1;
          end
          w_divNext = w_tickCycle ? '0 : r_divCnt + CW'(1);
          // The tick sum uses r_code, so a load in the same cycle only affects later ticks.
          if (w_tickCycle) begin
            w_accNext = w_sum[WIDTH-1:0];
`ifdef DEADTIME_EN
            if (w_bit != r_vp) begin
              w_vpNext      = 1'b0;
              w_vnNext      = 1'b0;
              w_pendNext    = 1'b1;
              w_pendBitNext = w_bit;
            end else begin
              w_vpNext   = w_bit;
              w_vnNext   = ~w_bit;
              w_tickNext = 1'b1;
            end
`else
            w_vpNext   = w_bit;
            w_vnNext   = ~w_bit;
            w_tickNext = 1'b1;
`endif
          end
`ifdef DEADTIME_EN
          else if (r_pend) begin
            w_vpNext   = r_pendBit;
            w_vnNext   = ~r_pendBit;
            w_tickNext = 1'b1;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code    <= '0;
      r_acc     <= '0;
      r_divCnt  <= '0;
      r_vp      <= 1'b0;
      r_vn      <= 1'b0;
      r_tick    <= 1'b0;
      r_loadAck <= 1'b0;
      r_active  <= 1'b0;
`ifdef DEADTIME_EN
      r_pend    <= 1'b0;
      r_pendBit <= 1'b0;
`endif
    end else begin
      r_code    <= w_codeNext;
      r_acc     <= w_accNext;
      r_divCnt  <= w_divNext;
      r_vp      <= w_vpNext;
      r_vn      <= w_vnNext;
      r_tick    <= w_tickNext;
      r_loadAck <= w_ackNext;
      r_active  <= w_activeNext;
`ifdef DEADTIME_EN
      r_pend    <= w_pendNext;
      r_pendBit <= w_pendBitNext;
`endif
    end
  end

  assign bus.vp_out   = r_vp;
  assign bus.vn_out   = r_vn;
  assign bus.tick     = r_tick;
  assign bus.load_ack = r_loadAck;
  assign bus.active   = r_active;

endmodule

// File: tb/tb_pdm_diff_driver.sv
// Scoreboard bench for pdm_diff_driver: stimulus queues hand-computed vp bits,
// a negedge monitor pops one per tick and checks vp, vn and tick spacing.
module tb_pdm_diff_driver;

  localparam int WIDTH = 8;
  localparam int DIV   = 4;
`ifdef DEADTIME_EN
  // The last tick before the aligned load arrives one cycle late after a break.
  localparam int ALIGN_WAIT = 2;
`else
  localparam int ALIGN_WAIT = 3;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pdm_diff_driver_if #(.WIDTH(WIDTH)) bus ();

  pdm_diff_driver #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checkCount = 0;
  int   passCount  = 0;
  int   cycle      = 0;
  logic expQ[$];
  logic havePrev   = 1'b0;
`ifdef DEADTIME_EN
  logic lastTickVp = 1'b0;
  logic prevVp     = 1'b0;
  logic prevVn     = 1'b0;
`else
  int   lastTickCycle = 0;
`endif

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic enaV, input logic loadV, input logic [WIDTH-1:0] codeV);
    bus.ena     = enaV;
    bus.load    = loadV;
    bus.code_in = codeV;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  task automatic waitTicks(input int n, input string tag);
    int seen   = 0;
    int budget = n * DIV * 2 + 16;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (bus.tick) seen++;
    end
    checkOutput({tag, "_tick_count"}, seen, n);
  endtask

  task automatic pushBits(input logic [7:0] pat, input int len, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = len - 1; i >= 0; i--)
        expQ.push_back(pat[i]);
  endtask

  // Monitor: scoreboard pop on every tick plus per-cycle exclusivity.
  always @(negedge clk) begin
    logic expBit;
    cycle++;
    checkOutput("vp_vn_exclusive", int'(bus.vp_out & bus.vn_out), 0);
    if (!bus.active) havePrev = 1'b0;
    if (bus.tick) begin
      checkOutput("tick_queued", int'(expQ.size() != 0), 1);
      if (expQ.size() != 0) begin
        expBit = expQ.pop_front();
        checkOutput("vp_bit", int'(bus.vp_out), int'(expBit));
        checkOutput("vn_complement", int'(bus.vn_out), int'(!expBit));
      end
`ifdef DEADTIME_EN
      if (havePrev && bus.vp_out != lastTickVp)
        checkOutput("deadtime_break", int'(prevVp | prevVn), 0);
      lastTickVp = bus.vp_out;
`else
      if (havePrev) checkOutput("tick_interval", cycle - lastTickCycle, DIV);
      lastTickCycle = cycle;
`endif
      havePrev = 1'b1;
    end
`ifdef DEADTIME_EN
    prevVp = bus.vp_out;
    prevVn = bus.vn_out;
`endif
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.ena     = 1'b0;
    bus.load    = 1'b0;
    bus.code_in = '0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_vp", int'(bus.vp_out), 0);
    checkOutput("reset_vn", int'(bus.vn_out), 0);
    checkOutput("reset_tick", int'(bus.tick), 0);
    checkOutput("reset_active", int'(bus.active), 0);
    checkOutput("reset_ack", int'(bus.load_ack), 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b0, 1'b1, 8'd77);
    checkOutput("ack_when_disabled", int'(bus.load_ack), 0);
    checkOutput("active_when_disabled", int'(bus.active), 0);
    bus.ena = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("idle_without_load", int'(bus.active), 0);

    // code 128 from acc=0: 0,1,0,1,...
    pushBits(8'b0000_0001, 2, 4);
    applyStimulus(1'b1, 1'b1, 8'd128);
    checkOutput("ack_128", int'(bus.load_ack), 1);
    checkOutput("active_run", int'(bus.active), 1);
    @(negedge clk);
    checkOutput("ack_single_pulse", int'(bus.load_ack), 0);
    waitTicks(8, "run128");

    // code 64 from acc=0: 0,0,0,1 repeating
    pushBits(8'b0000_0001, 4, 2);
    applyStimulus(1'b1, 1'b1, 8'd64);
    checkOutput("ack_64", int'(bus.load_ack), 1);
    waitTicks(8, "run64");

    // load 192 in the tick cycle: that tick still uses 64 (acc 0->64), then 192 from acc=64
    pushBits(8'b0101_1101, 8, 1);
    repeat (ALIGN_WAIT) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 8'd192);
    checkOutput("ack_192", int'(bus.load_ack), 1);
    @(negedge clk);
    checkOutput("ack_192_single", int'(bus.load_ack), 0);
    waitTicks(7, "run192");

    bus.ena = 1'b0;
    @(negedge clk);
    checkOutput("ena_drop_vp", int'(bus.vp_out), 0);
    checkOutput("ena_drop_vn", int'(bus.vn_out), 0);
    checkOutput("ena_drop_active", int'(bus.active), 0);
    checkOutput("ena_drop_tick", int'(bus.tick), 0);
    bus.ena = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("no_auto_restart", int'(bus.active), 0);

    // restart at 128 must begin from a cleared accumulator
    pushBits(8'b0000_0001, 2, 2);
    applyStimulus(1'b1, 1'b1, 8'd128);
    checkOutput("ack_restart", int'(bus.load_ack), 1);
    waitTicks(4, "restart128");

    pushBits(8'b0000_0000, 8, 8);
    applyStimulus(1'b1, 1'b1, 8'd0);
    waitTicks(64, "code0");

    // code 255 from acc=0: first tick 0, then 255 ones
    expQ.push_back(1'b0);
    pushBits(8'b1111_1111, 5, 51);
    applyStimulus(1'b1, 1'b1, 8'd255);
    waitTicks(256, "code255");

    bus.code_in = 8'd64;
    bus.load    = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    checkOutput("ack_before_reset", int'(bus.load_ack), 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_ack", int'(bus.load_ack), 0);
    checkOutput("async_reset_vp", int'(bus.vp_out), 0);
    checkOutput("async_reset_vn", int'(bus.vn_out), 0);
    checkOutput("async_reset_active", int'(bus.active), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("post_reset_idle", int'(bus.active), 0);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
